// File: rtl/booth_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
package booth_pkg;

    localparam int DIV_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Counter must be able to hold the iteration count 0..width
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_divider_if.sv
// Start/hold handshake and operand/result bus of the divider.
// Carries div_zero only when DIV_ZERO_DETECT_EN is defined.
interface booth_divider_if import booth_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);
    logic             en;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             busy;
    logic             done;
`ifdef DIV_ZERO_DETECT_EN
    logic             div_zero;

    modport master (output en, A, B, input quot, rem, busy, done, div_zero);
    modport slave  (input en, A, B, output quot, rem, busy, done, div_zero);
`else
    modport master (output en, A, B, input quot, rem, busy, done);
    modport slave  (input en, A, B, output quot, rem, busy, done);
`endif
endinterface

// File: rtl/booth_divider_restore_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract |B|.
module div_restore_step import booth_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   pr,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] bmag,
    output logic [WIDTH:0]   pr_next,
    output logic             q_bit
);
    logic [WIDTH+1:0] shift_s;
    logic [WIDTH+1:0] diff_s;

    // A clear sign bit on the trial difference means |B| fits: keep it and emit a 1
    always_comb begin
        shift_s = {pr, next_bit};
        diff_s  = shift_s - {2'b00, bmag};
        q_bit   = ~diff_s[WIDTH+1];
        if (q_bit) begin
            pr_next = diff_s[WIDTH:0];
        end else begin
            pr_next = shift_s[WIDTH:0];
        end
    end
endmodule

// File: rtl/booth_divider.sv
// Sequential signed restoring divider, one quotient bit per clock, en/done handshake.
// Optional DIV_ZERO_DETECT_EN short-circuits B == 0 and raises div_zero.
module booth_divider import booth_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input logic           clk,
    input logic           rst_n,
    booth_divider_if.slave bus
);
    localparam int               CNT_W   = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH - 1);

    div_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH:0]   pr_r, pr_s, step_pr_s;
    logic [WIDTH-1:0] qa_r, qa_s, bmag_r, bmag_s;
    logic             sa_r, sa_s, sb_r, sb_s, step_q_s;
    logic [WIDTH-1:0] quot_r, quot_s, rem_r, rem_s;
    logic             busy_r, busy_s, done_r, done_s;
    logic [WIDTH-1:0] amag_s, bmag_in_s, qmag_neg_s, rmag_s;
`ifdef DIV_ZERO_DETECT_EN
    logic             dz_r, dz_s, div_zero_r, div_zero_s;
`endif

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .pr       (pr_r),
        .next_bit (qa_r[WIDTH-1]),
        .bmag     (bmag_r),
        .pr_next  (step_pr_s),
        .q_bit    (step_q_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; dropping en anywhere returns to IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.en) begin
`ifdef DIV_ZERO_DETECT_EN
                    state_s = (bus.B == {WIDTH{1'b0}}) ? FIX : ITER;
`else
                    state_s = ITER;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            ITER: begin
                if (!bus.en) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_END) begin
                    state_s = FIX;
                end else begin
                    state_s = ITER;
                end
            end
            FIX:     state_s = bus.en ? DONE : IDLE;
            DONE:    state_s = bus.en ? DONE : IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath and output next values; |-2^(WIDTH-1)| is exact as an unsigned magnitude
    always_comb begin
        amag_s     = bus.A[WIDTH-1] ? (~bus.A + ONE_W) : bus.A;
        bmag_in_s  = bus.B[WIDTH-1] ? (~bus.B + ONE_W) : bus.B;
        qmag_neg_s = ~qa_r + ONE_W;
        rmag_s     = pr_r[WIDTH-1:0];
        cnt_s      = cnt_r;
        pr_s       = pr_r;
        qa_s       = qa_r;
        bmag_s     = bmag_r;
        sa_s       = sa_r;
        sb_s       = sb_r;
        quot_s     = quot_r;
        rem_s      = rem_r;
`ifdef DIV_ZERO_DETECT_EN
        dz_s       = dz_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.en) begin
                    sa_s   = bus.A[WIDTH-1];
                    sb_s   = bus.B[WIDTH-1];
                    bmag_s = bmag_in_s;
                    cnt_s  = {CNT_W{1'b0}};
                    pr_s   = {(WIDTH+1){1'b0}};
                    qa_s   = amag_s;
`ifdef DIV_ZERO_DETECT_EN
                    dz_s   = (bus.B == {WIDTH{1'b0}});
                    if (bus.B == {WIDTH{1'b0}}) begin
                        pr_s = {1'b0, amag_s};
                        qa_s = {WIDTH{1'b1}};
                    end else begin
                        pr_s = {(WIDTH+1){1'b0}};
                    end
`endif
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ITER: begin
                if (bus.en) begin
                    pr_s  = step_pr_s;
                    qa_s  = {qa_r[WIDTH-2:0], step_q_s};
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            FIX: begin
                if (bus.en) begin
                    quot_s = (sa_r ^ sb_r) ? qmag_neg_s : qa_r;
                    rem_s  = sa_r ? (~rmag_s + ONE_W) : rmag_s;
`ifdef DIV_ZERO_DETECT_EN
                    if (dz_r) begin
                        quot_s = {WIDTH{1'b1}};
                    end else begin
                        quot_s = (sa_r ^ sb_r) ? qmag_neg_s : qa_r;
                    end
`endif
                end else begin
                    quot_s = quot_r;
                end
            end
            DONE:    cnt_s = cnt_r;
            default: cnt_s = cnt_r;
        endcase
        busy_s = (state_s == ITER) || (state_s == FIX);
        done_s = (state_s == DONE);
`ifdef DIV_ZERO_DETECT_EN
        div_zero_s = dz_r && (state_s == DONE);
`endif
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            pr_r   <= {(WIDTH+1){1'b0}};
            qa_r   <= {WIDTH{1'b0}};
            bmag_r <= {WIDTH{1'b0}};
            sa_r   <= 1'b0;
            sb_r   <= 1'b0;
            quot_r <= {WIDTH{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_r       <= 1'b0;
            div_zero_r <= 1'b0;
`endif
        end else begin
            cnt_r  <= cnt_s;
            pr_r   <= pr_s;
            qa_r   <= qa_s;
            bmag_r <= bmag_s;
            sa_r   <= sa_s;
            sb_r   <= sb_s;
            quot_r <= quot_s;
            rem_r  <= rem_s;
            busy_r <= busy_s;
            done_r <= done_s;
`ifdef DIV_ZERO_DETECT_EN
            dz_r       <= dz_s;
            div_zero_r <= div_zero_s;
`endif
        end
    end

    assign bus.quot = quot_r;
    assign bus.rem  = rem_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_zero = div_zero_r;
`endif

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider (WIDTH=16): vector table, scoreboard queue, corner sequences.
// Honours DIV_ZERO_DETECT_EN for the B == 0 expectations.
module tb_booth_divider;
    import booth_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
        logic         dz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    vec_t vecs[0:11];

    booth_divider_if #(.WIDTH(W)) bus ();

    booth_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start one operation, track busy edge by edge, then compare against the scoreboard
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r, input bit scramble);
        exp_t e;
        int   edges;
        bit   got_done;
        bit   busy_bad;
        e.q   = q;
        e.r   = r;
        e.lat = W + 2;
        e.dz  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        if (b == {W{1'b0}}) begin
            e.q   = {W{1'b1}};
            e.r   = a;
            e.lat = 2;
            e.dz  = 1'b1;
        end
`endif
        sb_q.push_back(e);
        bus.A  = a;
        bus.B  = b;
        bus.en = 1'b1;
        edges    = 0;
        got_done = 1'b0;
        busy_bad = 1'b0;
        while (!got_done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (scramble && edges == 3) begin
                bus.A = W'($urandom);
                bus.B = W'($urandom);
            end
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
            end else if (bus.busy !== 1'b1) begin
                busy_bad = 1'b1;
            end
        end
        e = sb_q.pop_front();
        chk($sformatf("latency %0d/%0d", $signed(a), $signed(b)), edges, e.lat);
        chk($sformatf("busy_during %0d/%0d", $signed(a), $signed(b)), {31'd0, busy_bad}, 32'd0);
        chk($sformatf("busy_at_done %0d/%0d", $signed(a), $signed(b)), {31'd0, bus.busy}, 32'd0);
        chk($sformatf("quot %0d/%0d", $signed(a), $signed(b)), {16'd0, bus.quot}, {16'd0, e.q});
        chk($sformatf("rem %0d/%0d", $signed(a), $signed(b)), {16'd0, bus.rem}, {16'd0, e.r});
`ifdef DIV_ZERO_DETECT_EN
        chk($sformatf("div_zero %0d/%0d", $signed(a), $signed(b)), {31'd0, bus.div_zero}, {31'd0, e.dz});
`endif
        @(posedge clk);
        #1;
        chk("done_hold", {31'd0, bus.done}, 32'd1);
        chk("quot_hold", {16'd0, bus.quot}, {16'd0, e.q});
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        chk("done_clear", {31'd0, bus.done}, 32'd0);
        chk("quot_keep", {16'd0, bus.quot}, {16'd0, e.q});
        chk("rem_keep", {16'd0, bus.rem}, {16'd0, e.r});
`ifdef DIV_ZERO_DETECT_EN
        chk("div_zero_clear", {31'd0, bus.div_zero}, 32'd0);
`endif
    endtask

    initial begin
        bit seen_done;
        checks = 0;
        errors = 0;
        vecs[0]  = '{a: 16'd100,   b: 16'd7,      q: 16'd14,     r: 16'd2};
        vecs[1]  = '{a: -16'sd100, b: 16'd7,      q: -16'sd14,   r: -16'sd2};
        vecs[2]  = '{a: 16'd100,   b: -16'sd7,    q: -16'sd14,   r: 16'd2};
        vecs[3]  = '{a: 16'h8000,  b: 16'hFFFF,   q: 16'h8000,   r: 16'd0};
        vecs[4]  = '{a: 16'h8000,  b: 16'd1,      q: 16'h8000,   r: 16'd0};
        vecs[5]  = '{a: 16'd7,     b: 16'd0,      q: 16'hFFFF,   r: 16'd7};
        vecs[6]  = '{a: -16'sd7,   b: 16'd0,      q: 16'd1,      r: -16'sd7};
        vecs[7]  = '{a: 16'd0,     b: -16'sd5,    q: 16'd0,      r: 16'd0};
        vecs[8]  = '{a: 16'h7FFF,  b: 16'h8000,   q: 16'd0,      r: 16'h7FFF};
        vecs[9]  = '{a: 16'h8000,  b: 16'h8000,   q: 16'd1,      r: 16'd0};
        vecs[10] = '{a: -16'sd1,   b: 16'd2,      q: 16'd0,      r: -16'sd1};
        vecs[11] = '{a: 16'd1000,  b: 16'd3,      q: 16'd333,    r: 16'd1};

        rst_n  = 1'b0;
        bus.en = 1'b0;
        bus.A  = 16'd0;
        bus.B  = 16'd0;
        #1;
        chk("reset_quot", {16'd0, bus.quot}, 32'd0);
        chk("reset_rem", {16'd0, bus.rem}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
`ifdef DIV_ZERO_DETECT_EN
        chk("reset_div_zero", {31'd0, bus.div_zero}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0);
        end

        // Abort: en sampled low on edge 6, result registers keep 1000/3 from the table
        bus.A  = 16'd1000;
        bus.B  = 16'd3;
        bus.en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.en = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen_done = 1'b1;
            if (i == 0) chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        end
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);
        chk("abort_quot_kept", {16'd0, bus.quot}, 32'd333);
        run_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);

        // Asynchronous reset mid-ITER clears outputs without a clock edge
        bus.A  = 16'd100;
        bus.B  = 16'd7;
        bus.en = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_quot", {16'd0, bus.quot}, 32'd0);
        chk("async_rst_rem", {16'd0, bus.rem}, 32'd0);
        chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_rst_done", {31'd0, bus.done}, 32'd0);
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(16'd9, -16'sd2, -16'sd4, 16'd1, 1'b0);

        // Operands changed during ITER must not affect the result
        run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b1);
        run_op(-16'sd12345, 16'd99, -16'sd124, -16'sd69, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
